// File: rtl/time_set_controller_pkg.sv
// Shared types for the time-setting controller: FSM states, blink-field codes, width helper.
// Pure declarations; no logic, no latency.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;

    function automatic int cnt_w(input int max);
        return $clog2(max) + 1;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button/time-value bundle between the user front panel and the time-set controller.
// Plain level signals; no handshake, no backpressure.
interface time_set_controller_if #(
    parameter int HOURS_MAX   = 24,
    parameter int MINUTES_MAX = 60
);
    import clock_pkg::*;

    localparam int HW = cnt_w(HOURS_MAX);
    localparam int MW = cnt_w(MINUTES_MAX);

    logic          repeat_tick;
    logic          btn_mode;
    logic          btn_inc;
    logic          btn_dec;
    logic [HW-1:0] cur_hours;
    logic [MW-1:0] cur_minutes;
    logic          load_time;
    logic [HW-1:0] new_hours;
    logic [MW-1:0] new_minutes;
    logic [MW-1:0] new_seconds;
    logic [1:0]    edit_field;
    logic          edit_active;

    modport master (
        output repeat_tick, btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
        input  load_time, new_hours, new_minutes, new_seconds, edit_field, edit_active
    );

    modport slave (
        input  repeat_tick, btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
        output load_time, new_hours, new_minutes, new_seconds, edit_field, edit_active
    );

endinterface

// File: rtl/time_set_controller_button.sv
// Press-edge detector with optional auto-repeat; evt is a registered 1-cycle pulse,
// one cycle after the level first rises. No backpressure: events are never held.
module button_repeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_repeat_tick,
    input  logic i_btn,
    output logic o_evt
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);

    logic          r_prev;
    logic          r_evt;
    logic          r_rep;
    logic [CW-1:0] r_cnt;

    logic          w_edge;
    logic          w_fire;
    logic          w_rep_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // r_rep distinguishes the initial hold delay from the steady repeat period
    always_comb begin
        w_edge    = i_btn & ~r_prev;
        w_fire    = 1'b0;
        w_rep_nxt = r_rep;
        w_cnt_nxt = r_cnt;
        if (!i_btn) begin
            w_rep_nxt = 1'b0;
            w_cnt_nxt = '0;
        end else if (REPEAT_EN && i_repeat_tick) begin
            if (r_rep ? (r_cnt == CW'(REPEAT_RATE - 1)) : (r_cnt == CW'(REPEAT_DELAY - 1))) begin
                w_fire    = 1'b1;
                w_rep_nxt = 1'b1;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_evt  <= 1'b0;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_btn;
            r_evt  <= w_edge | w_fire;
            r_rep  <= w_rep_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_evt = r_evt;

endmodule

// File: rtl/time_set_controller.sv
// Time-set FSM: snapshot, edit hours then minutes, commit with a 1-cycle load strobe.
// btn_mode rise to load_time is 2 cycles from EDIT_M; no backpressure on load_time.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int HOURS_MAX    = 24,
    parameter int MINUTES_MAX  = 60,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter int TIMEOUT      = 1000
) (
    input logic clk,
    input logic rst,
    time_set_controller_if.slave bus
);

    localparam int HW = cnt_w(HOURS_MAX);
    localparam int MW = cnt_w(MINUTES_MAX);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          w_mode_evt;
    logic          w_inc_evt;
    logic          w_dec_evt;
    logic          w_inc;
    logic          w_dec;
    logic          w_any_evt;
    state_t        w_state_nxt;
    logic [HW-1:0] w_sh_nxt;
    logic [MW-1:0] w_sm_nxt;
    logic [TW-1:0] w_to_nxt;

    state_t        r_state;
    logic [HW-1:0] r_sh;
    logic [MW-1:0] r_sm;
    logic [TW-1:0] r_to;
    logic          r_load;
    logic [HW-1:0] r_new_h;
    logic [MW-1:0] r_new_m;
    logic [1:0]    r_field;
    logic          r_active;

    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)) u_mode (
        .clk(clk), .rst(rst), .i_repeat_tick(bus.repeat_tick), .i_btn(bus.btn_mode), .o_evt(w_mode_evt)
    );
    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)) u_inc (
        .clk(clk), .rst(rst), .i_repeat_tick(bus.repeat_tick), .i_btn(bus.btn_inc), .o_evt(w_inc_evt)
    );
    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)) u_dec (
        .clk(clk), .rst(rst), .i_repeat_tick(bus.repeat_tick), .i_btn(bus.btn_dec), .o_evt(w_dec_evt)
    );

    // Field edit is applied before the mode advance, so both can happen in one cycle
    always_comb begin
        w_inc       = w_inc_evt & ~w_dec_evt;
        w_dec       = w_dec_evt & ~w_inc_evt;
        w_any_evt   = w_mode_evt | w_inc_evt | w_dec_evt;
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_sm_nxt    = r_sm;
        w_to_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (w_mode_evt) begin
                    w_sh_nxt    = (bus.cur_hours   >= HW'(HOURS_MAX))   ? '0 : bus.cur_hours;
                    w_sm_nxt    = (bus.cur_minutes >= MW'(MINUTES_MAX)) ? '0 : bus.cur_minutes;
                    w_state_nxt = EDIT_H;
                end
            end
            EDIT_H, EDIT_M: begin
                if (r_state == EDIT_H) begin
                    if (w_inc)      w_sh_nxt = (r_sh == HW'(HOURS_MAX - 1)) ? '0 : r_sh + HW'(1);
                    else if (w_dec) w_sh_nxt = (r_sh == '0) ? HW'(HOURS_MAX - 1) : r_sh - HW'(1);
                    if (w_mode_evt) w_state_nxt = EDIT_M;
                end else begin
                    if (w_inc)      w_sm_nxt = (r_sm == MW'(MINUTES_MAX - 1)) ? '0 : r_sm + MW'(1);
                    else if (w_dec) w_sm_nxt = (r_sm == '0) ? MW'(MINUTES_MAX - 1) : r_sm - MW'(1);
                    if (w_mode_evt) w_state_nxt = COMMIT;
                end
                if (w_any_evt) begin
                    w_to_nxt = '0;
                end else if (bus.repeat_tick) begin
                    if (r_to == TW'(TIMEOUT - 1)) w_state_nxt = IDLE;
                    else                          w_to_nxt    = r_to + TW'(1);
                end else begin
                    w_to_nxt = r_to;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_sm     <= '0;
            r_to     <= '0;
            r_load   <= 1'b0;
            r_new_h  <= '0;
            r_new_m  <= '0;
            r_field  <= FIELD_NONE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sh     <= w_sh_nxt;
            r_sm     <= w_sm_nxt;
            r_to     <= w_to_nxt;
            r_load   <= (w_state_nxt == COMMIT);
            r_new_h  <= w_sh_nxt;
            r_new_m  <= w_sm_nxt;
            r_field  <= (w_state_nxt == EDIT_H) ? FIELD_HOURS :
                        (w_state_nxt == EDIT_M) ? FIELD_MINUTES : FIELD_NONE;
            r_active <= (w_state_nxt == EDIT_H) || (w_state_nxt == EDIT_M);
        end
    end

    assign bus.load_time   = r_load;
    assign bus.new_hours   = r_new_h;
    assign bus.new_minutes = r_new_m;
    assign bus.new_seconds = '0;
    assign bus.edit_field  = r_field;
    assign bus.edit_active = r_active;

endmodule
